alien_march_ctrl: RTL
=====================

Name: alien_march_ctrl

Overview:
Formation-level march sequencer for the alien grid. Paces movement in frame ticks, with the pace speeding up as aliens die. Detects when the live formation reaches a playfield edge, then issues a descend-and-reverse step. Produces shared X/Y offsets that every alien adds to its initial position, and flags wave-clear and landed end conditions to game control.

Parameters:
NUM_ROWS, 3, alien grid rows
NUM_COLS, 5, alien grid columns
ALIEN_SPACING_X, 64, column pitch in pixels
ALIEN_SPACING_Y, 32, row pitch in pixels
START_X, 100, initial X of column 0
START_Y, 50, initial Y of row 0
ALIEN_W, 32, alien sprite width
ALIEN_H, 16, alien sprite height
STEP_X, 8, horizontal pixels per march step
STEP_Y, 16, vertical pixels per descend step
FIELD_LEFT, 8, leftmost legal pixel
FIELD_RIGHT, 632, rightmost legal pixel (exclusive bound)
LAND_Y, 440, formation bottom at/after which aliens have landed
MIN_PERIOD, 2, frames per step floor
FRAMES_PER_ALIEN, 1, extra frames per step per live alien

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per video frame
start  in  1  one-cycle pulse: begin/restart wave
alive_matrix  in  NUM_ROWS*NUM_COLS  live flags, [row][col] packed
offset_x  out  16  signed two's-complement formation X offset
offset_y  out  16  unsigned formation Y offset
direction  out  1  1 = moving right, 0 = moving left
step_pulse  out  1  one-cycle pulse on every offset update
marching  out  1  high while in MARCH
wave_clear  out  1  sticky: all aliens dead
landed  out  1  sticky: formation reached LAND_Y

Behaviour:
- Reset (async, rst_n low): state IDLE, offset_x=0, offset_y=0, direction=1, frame_cnt=0, step_pulse=0, marching=0, wave_clear=0, landed=0.
- States: IDLE, MARCH, HALT.
- IDLE/HALT + start:
  - Next cycle: offsets zeroed, direction=1, frame_cnt=0, flags cleared, state MARCH.
  - start in MARCH is ignored.
- Combinational extents, all computed from alive_matrix:
  - min_col / max_col: lowest / highest column holding any live alien.
  - max_row: highest row holding any live alien.
  - alive_cnt: popcount, width ≥ clog2(NUM_ROWS*NUM_COLS+1).
- Extent arithmetic (17-bit signed):
  - left_edge = START_X + offset_x + min_col*ALIEN_SPACING_X
  - right_edge = START_X + offset_x + max_col*ALIEN_SPACING_X + ALIEN_W
  - bottom = START_Y + offset_y + max_row*ALIEN_SPACING_Y + ALIEN_H
- period = MIN_PERIOD + alive_cnt*FRAMES_PER_ALIEN, re-evaluated every cycle.
- MARCH, priority order each cycle:
  1. alive_matrix all zero → next cycle state HALT, wave_clear=1. No step; overrides a coincident tick.
  2. frame_tick with frame_cnt+1 >= period → step, frame_cnt=0.
  3. frame_tick otherwise → frame_cnt+1.
- Step (registered; offsets and step_pulse update together, 1 cycle after the tick):
  - Right: if right_edge+STEP_X > FIELD_RIGHT, descend; else offset_x += STEP_X.
  - Left: if left_edge-STEP_X < FIELD_LEFT, descend; else offset_x -= STEP_X.
  - Descend: offset_y += STEP_Y, direction toggles, offset_x unchanged.
- Landing check: after a descend, if the new bottom >= LAND_Y, the next cycle sets landed=1 and state HALT. step_pulse still fires for that descend.
- Period shrink mid-count: the current frame_cnt is compared against the new period. If frame_cnt already >= period, the next tick steps.
- HALT: offsets frozen, step_pulse=0, ticks ignored. Flags hold until start or reset.
- Outputs: marching = (state==MARCH). All outputs are registered.
- Reset mid-march: immediate return to reset values.

Test Plan:
- Reset, then start with all 15 alive (period 17) → step_pulse one cycle after every 17th frame_tick; first step gives offset_x=8, direction=1.
- Full grid, continuous marching → offset_x reaches 240 after 30 steps. 31st step gives offset_y=16, offset_x=240, direction=0. 32nd step gives offset_x=232.
- Clear column 4 at offset_x=240 while moving right → right edge shrinks to 324+240. Next steps continue right, no descend, until right_edge+8 > 632.
- Leave one alien alive (period 3) → step every 3rd tick. Clear it coincident with a qualifying tick → no step_pulse, wave_clear=1, state HALT.
- Run to landing (max_row=2) → the descend reaching offset_y=320 (bottom=450) pulses step_pulse, then landed=1, marching=0. Further ticks leave offsets unchanged. start re-enters MARCH with offsets 0 and flags cleared.
- Drop rst_n mid-count after 5 ticks → all outputs at reset values asynchronously. After release, start and 17 ticks produce the first step.

Source files
------------

// File: rtl/alien_march_ctrl.sv
// Formation march sequencer: paces alien-grid steps by frame ticks, bounces off the
// playfield edges with a descend-and-reverse, and flags wave-clear / landed.
module alien_march_ctrl #(
  parameter int NUM_ROWS         = 3,
  parameter int NUM_COLS         = 5,
  parameter int ALIEN_SPACING_X  = 64,
  parameter int ALIEN_SPACING_Y  = 32,
  parameter int START_X          = 100,
  parameter int START_Y          = 50,
  parameter int ALIEN_W          = 32,
  parameter int ALIEN_H          = 16,
  parameter int STEP_X           = 8,
  parameter int STEP_Y           = 16,
  parameter int FIELD_LEFT       = 8,
  parameter int FIELD_RIGHT      = 632,
  parameter int LAND_Y           = 440,
  parameter int MIN_PERIOD       = 2,
  parameter int FRAMES_PER_ALIEN = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_tick,
  input  logic                         start,
  input  logic [NUM_ROWS*NUM_COLS-1:0] alive_matrix,
  output logic signed [15:0]           offset_x,
  output logic [15:0]                  offset_y,
  output logic                         direction,
  output logic                         step_pulse,
  output logic                         marching,
  output logic                         wave_clear,
  output logic                         landed
);

  typedef enum logic [1:0] {IDLE, MARCH, HALT} state_t;
  typedef logic signed [16:0] ext_t;

  localparam int NUM_ALIENS = NUM_ROWS * NUM_COLS;
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int AW = $clog2(NUM_ALIENS + 1);
  localparam int PW = $clog2(MIN_PERIOD + NUM_ALIENS * FRAMES_PER_ALIEN + 1);

  localparam ext_t START_X_E     = ext_t'(START_X);
  localparam ext_t START_Y_E     = ext_t'(START_Y);
  localparam ext_t SPACING_X_E   = ext_t'(ALIEN_SPACING_X);
  localparam ext_t SPACING_Y_E   = ext_t'(ALIEN_SPACING_Y);
  localparam ext_t ALIEN_W_E     = ext_t'(ALIEN_W);
  localparam ext_t ALIEN_H_E     = ext_t'(ALIEN_H);
  localparam ext_t STEP_X_E      = ext_t'(STEP_X);
  localparam ext_t STEP_Y_E      = ext_t'(STEP_Y);
  localparam ext_t FIELD_LEFT_E  = ext_t'(FIELD_LEFT);
  localparam ext_t FIELD_RIGHT_E = ext_t'(FIELD_RIGHT);
  localparam ext_t LAND_Y_E      = ext_t'(LAND_Y);
  localparam logic signed [15:0] STEP_X_O = 16'(STEP_X);
  localparam logic [15:0]        STEP_Y_O = 16'(STEP_Y);

  state_t               state, state_n;
  logic [PW-1:0]        frame_cnt, frame_cnt_n, period;
  logic [PW:0]          cnt_inc;
  logic                 tick_due, hit_edge;
  logic                 land_pending, land_pending_n;
  logic signed [15:0]   offset_x_n;
  logic [15:0]          offset_y_n;
  logic                 direction_n, step_pulse_n, marching_n, wave_clear_n, landed_n;

  logic [NUM_COLS-1:0]  col_any;
  logic [NUM_ROWS-1:0]  row_any;
  logic [CW-1:0]        min_col, max_col;
  logic [RW-1:0]        max_row;
  logic [AW-1:0]        alive_cnt;
  ext_t                 left_edge, right_edge, bottom;

  // Live-formation extents and population; alive_matrix bit index is row*NUM_COLS+col.
  always_comb begin
    col_any   = '0;
    row_any   = '0;
    alive_cnt = '0;
    min_col   = '0;
    max_col   = '0;
    max_row   = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        col_any[c] = col_any[c] | alive_matrix[r*NUM_COLS+c];
        row_any[r] = row_any[r] | alive_matrix[r*NUM_COLS+c];
        alive_cnt  = alive_cnt + AW'(alive_matrix[r*NUM_COLS+c]);
      end
    end
    for (int c = NUM_COLS - 1; c >= 0; c--) if (col_any[c]) min_col = CW'(c);
    for (int c = 0; c < NUM_COLS; c++)      if (col_any[c]) max_col = CW'(c);
    for (int r = 0; r < NUM_ROWS; r++)      if (row_any[r]) max_row = RW'(r);
  end

  assign left_edge  = START_X_E + ext_t'(offset_x) + ext_t'(min_col) * SPACING_X_E;
  assign right_edge = START_X_E + ext_t'(offset_x) + ext_t'(max_col) * SPACING_X_E + ALIEN_W_E;
  assign bottom     = START_Y_E + ext_t'(offset_y) + ext_t'(max_row) * SPACING_Y_E + ALIEN_H_E;

  // Period follows the live count every cycle, so a shrink mid-count lets the next tick step.
  assign period   = PW'(MIN_PERIOD) + PW'(alive_cnt) * PW'(FRAMES_PER_ALIEN);
  assign cnt_inc  = {1'b0, frame_cnt} + (PW+1)'(1);
  assign tick_due = cnt_inc >= {1'b0, period};
  assign hit_edge = direction ? (right_edge + STEP_X_E > FIELD_RIGHT_E)
                              : (left_edge - STEP_X_E < FIELD_LEFT_E);

  // NOTE: every signal is given a default before the case so no path leaves it unassigned,
  // which keeps this block purely combinational (no inferred latches).
  always_comb begin
    state_n        = state;
    frame_cnt_n    = frame_cnt;
    offset_x_n     = offset_x;
    offset_y_n     = offset_y;
    direction_n    = direction;
    step_pulse_n   = 1'b0;
    wave_clear_n   = wave_clear;
    landed_n       = landed;
    land_pending_n = 1'b0;
    unique case (state)
      IDLE, HALT: begin
        if (start) begin
          state_n      = MARCH;
          frame_cnt_n  = '0;
          offset_x_n   = '0;
          offset_y_n   = '0;
          direction_n  = 1'b1;
          wave_clear_n = 1'b0;
          landed_n     = 1'b0;
        end
      end
      MARCH: begin
        if (land_pending) begin
          landed_n = 1'b1;
          state_n  = HALT;
        end else if (alive_matrix == '0) begin
          wave_clear_n = 1'b1;
          state_n      = HALT;
        end else if (frame_tick) begin
          if (tick_due) begin
            frame_cnt_n  = '0;
            step_pulse_n = 1'b1;
            if (hit_edge) begin
              offset_y_n     = offset_y + STEP_Y_O;
              direction_n    = ~direction;
              land_pending_n = (bottom + STEP_Y_E >= LAND_Y_E);
            end else begin
              offset_x_n = direction ? offset_x + STEP_X_O : offset_x - STEP_X_O;
            end
          end else begin
            frame_cnt_n = cnt_inc[PW-1:0];
          end
        end
      end
      default: state_n = IDLE;
    endcase
    marching_n = (state_n == MARCH);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      frame_cnt    <= '0;
      offset_x     <= '0;
      offset_y     <= '0;
      direction    <= 1'b1;
      step_pulse   <= 1'b0;
      marching     <= 1'b0;
      wave_clear   <= 1'b0;
      landed       <= 1'b0;
      land_pending <= 1'b0;
    end else begin
      state        <= state_n;
      frame_cnt    <= frame_cnt_n;
      offset_x     <= offset_x_n;
      offset_y     <= offset_y_n;
      direction    <= direction_n;
      step_pulse   <= step_pulse_n;
      marching     <= marching_n;
      wave_clear   <= wave_clear_n;
      landed       <= landed_n;
      land_pending <= land_pending_n;
    end
  end

endmodule
